pla_preimage_enum: RTL and testbench

- Sequential enumerator that sweeps the full input space of an external single-output combinational function (any mapped PLA/benchmark netlist, up to N_IN inputs).
- Streams out every input vector x with f(x) == target over a valid/ready interface, then reports the total.
- Inverse-direction companion to the mapped benchmark netlists: takes a value y and returns its preimage set.
- Used for on-set/off-set extraction and cross-checking optimized netlists against original PLAs.

---
 rtl/pla_enum_pkg.sv | 16 +
 rtl/enum_out_reg.sv | 37 +++
 rtl/pla_preimage_enum.sv | 124 ++++++++++++
 tb/tb_pla_preimage_enum.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pla_enum_pkg.sv
// Shared types and constants for the PLA preimage enumerator.
package pla_enum_pkg;

  // Default number of function inputs and the last vector of a default sweep.
  localparam int N_IN_DEFAULT = 8;
  localparam int SWEEP_LAST   = 2**N_IN_DEFAULT - 1;

  // Sweep controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/enum_out_reg.sv
// Single-entry valid/ready output register. The owner may load only while
// free is high, so a held beat is never overwritten before it is accepted.
module enum_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         free
);

  // Empty, or its beat leaves at this edge.
  assign free = !valid || ready;

  // Hold one beat until the downstream handshake consumes it.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register here, data included, is reset so no stale vector
    // from an aborted sweep can ever be observed after rst.
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pla_preimage_enum.sv
// Sweeps every input vector of an external single-output function and
// streams out the vectors whose result equals the requested target value,
// then pulses done with the number of matches held on count.
module pla_preimage_enum
  import pla_enum_pkg::*;
#(
  parameter int N_IN  = N_IN_DEFAULT,
  parameter int CNT_W = N_IN + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             target,
  output logic [N_IN-1:0]  f_x,
  input  logic             f_y,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [N_IN-1:0]  m_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  // Final vector of the sweep: all ones, the sweep stops here without wrapping.
  localparam logic [N_IN-1:0] X_LAST = '1;

  state_t           state, next_state;
  logic [N_IN-1:0]  x_q;
  logic [CNT_W-1:0] count_q;
  logic             target_q;
  logic             done_q;

  logic match, free;
  logic accept, clr, load, advance, finish;

  assign match = (f_y == target_q);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register sees the pre-edge values of the others.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    // NOTE: every output of this block gets a default first; a missed branch
    // would otherwise infer a latch.
    next_state = state;
    accept     = 1'b0;
    clr        = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          clr        = 1'b1;
          next_state = SCAN;
        end
      end
      SCAN: begin
        if (match) begin
          // A match waits for room; f_x is re-evaluated next cycle.
          if (free) begin
            load    = 1'b1;
            advance = 1'b1;
          end
        end else begin
          advance = 1'b1;
        end
        if (advance && (x_q == X_LAST)) next_state = FLUSH;
      end
      FLUSH: begin
        // Done only once the final beat has left the output register.
        if (!m_valid || m_ready) begin
          finish     = 1'b1;
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Sweep vector, match counter, target latch and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= '0;
      count_q  <= '0;
      target_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept) begin
        target_q <= target;
        x_q      <= '0;
        count_q  <= '0;
      end else begin
        if (advance && (x_q != X_LAST)) x_q <= x_q + 1'b1;
        if (load) count_q <= count_q + CNT_W'(1);
      end
    end
  end

  enum_out_reg #(.W(N_IN)) u_out (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .load  (load),
    .d     (x_q),
    .ready (m_ready),
    .valid (m_valid),
    .data  (m_data),
    .free  (free)
  );

  assign f_x   = x_q;
  assign busy  = (state == SCAN) || (state == FLUSH);
  assign done  = done_q;
  assign count = count_q;

endmodule

// File: tb/tb_pla_preimage_enum.sv
// Self-checking bench for pla_preimage_enum: a table of sweeps checked
// against a scoreboard of expected matching vectors, plus hand-written
// sequences for mid-sweep reset and start-while-busy.
module tb_pla_preimage_enum;
  import pla_enum_pkg::*;

  localparam int N_IN  = N_IN_DEFAULT;
  localparam int CNT_W = N_IN + 1;
  localparam int NVEC  = SWEEP_LAST + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             target;
  logic [N_IN-1:0]  f_x;
  logic             f_y;
  logic             m_valid;
  logic             m_ready;
  logic [N_IN-1:0]  m_data;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;

  int fmode;
  int n_vec = 0;
  int n_err = 0;
  logic [N_IN-1:0] exp_q[$];

  pla_preimage_enum #(.N_IN(N_IN), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .target  (target),
    .f_x     (f_x),
    .f_y     (f_y),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .busy    (busy),
    .done    (done),
    .count   (count)
  );

  always #5 clk = ~clk;

  // External function under enumeration: 0 -> x==A5, 1 -> x[0], 2 -> 0, 3 -> 1.
  function automatic logic fmodel(input int mode, input logic [N_IN-1:0] x);
    case (mode)
      0:       return (x == 8'hA5);
      1:       return x[0];
      2:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  always_comb f_y = fmodel(fmode, f_x);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full sweep. rmode: 0 ready high, 1 ready toggling, 2 ready random.
  // exp_lat < 0 skips the latency check; inject_k >= 0 pulses start (with the
  // opposite target) that many cycles into the sweep.
  task automatic run_sweep(input string name, input int mode, input logic tgt,
                           input int rmode, input int exp_cnt, input int exp_lat,
                           input int inject_k);
    int              k;
    bit              fin;
    logic            stall;
    logic [N_IN-1:0] hold;
    logic [N_IN-1:0] exp_x;
    fmode = mode;
    exp_q.delete();
    for (int x = 0; x < NVEC; x++) begin
      logic [N_IN-1:0] xv;
      xv = x[N_IN-1:0];
      if (fmodel(mode, xv) == tgt) exp_q.push_back(xv);
    end
    start  = 1'b1;
    target = tgt;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    target = ~tgt;
    k = 0; fin = 1'b0; stall = 1'b0; hold = '0;
    check({name, " busy_after_start"}, 32'(busy), 32'd1);
    while (!fin) begin
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = (k[0] == 1'b0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      start = (k == inject_k);
      if (stall) begin
        check({name, " stall_valid"}, 32'(m_valid), 32'd1);
        check({name, " stall_data"}, 32'(m_data), 32'(hold));
      end
      if (done) begin
        fin = 1'b1;
        if (exp_lat >= 0) check({name, " latency"}, k, exp_lat);
      end else if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL %s extra_beat: got 0x%0h expected none", name, m_data);
        end else begin
          exp_x = exp_q.pop_front();
          check({name, " m_data"}, 32'(m_data), 32'(exp_x));
        end
      end
      stall = m_valid && !m_ready;
      hold  = m_data;
      if (!fin && k > 4000) begin
        n_vec++; n_err++;
        $display("FAIL %s timeout: got no done expected done by cycle 4000", name);
        fin = 1'b1;
      end
      if (!fin) begin
        @(negedge clk);
        k++;
      end
    end
    start   = 1'b0;
    m_ready = 1'b1;
    check({name, " count"}, 32'(count), exp_cnt);
    check({name, " missing_beats"}, exp_q.size(), 0);
    check({name, " valid_in_done"}, 32'(m_valid), 32'd0);
    check({name, " busy_in_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({name, " done_one_cycle"}, 32'(done), 32'd0);
    check({name, " count_held"}, 32'(count), exp_cnt);
  endtask

  typedef struct {
    string name;
    int    mode;
    logic  tgt;
    int    rmode;
    int    exp_cnt;
    int    exp_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int w;
    vecs[0] = '{"a5_t1",       0, 1'b1, 0, 1,   257};
    vecs[1] = '{"a5_t0",       0, 1'b0, 0, 255, 257};
    vecs[2] = '{"odd_toggle",  1, 1'b1, 1, 128, -1};
    vecs[3] = '{"empty",       2, 1'b1, 0, 0,   257};
    vecs[4] = '{"full",        3, 1'b1, 0, 256, 257};
    vecs[5] = '{"full_random", 3, 1'b1, 2, 256, -1};
    vecs[6] = '{"even_toggle", 1, 1'b0, 1, 128, -1};

    rst = 1'b1; start = 1'b0; target = 1'b0; m_ready = 1'b0; fmode = 0;
    repeat (3) @(negedge clk);
    check("reset f_x", 32'(f_x), 32'd0);
    check("reset m_valid", 32'(m_valid), 32'd0);
    check("reset m_data", 32'(m_data), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset count", 32'(count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table of sweeps; each after the first starts from DONE.
    for (int i = 0; i < 7; i++)
      run_sweep(vecs[i].name, vecs[i].mode, vecs[i].tgt, vecs[i].rmode,
                vecs[i].exp_cnt, vecs[i].exp_lat, -1);

    // Asynchronous reset mid-sweep with a beat held in the output register.
    fmode = 3; m_ready = 1'b1;
    start = 1'b1; target = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (f_x != 8'h40 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check("mid_rst reached_40", 32'(f_x), 32'h40);
    check("mid_rst valid_before", 32'(m_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst f_x", 32'(f_x), 32'd0);
    check("mid_rst m_valid", 32'(m_valid), 32'd0);
    check("mid_rst m_data", 32'(m_data), 32'd0);
    check("mid_rst busy", 32'(busy), 32'd0);
    check("mid_rst done", 32'(done), 32'd0);
    check("mid_rst count", 32'(count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_sweep("after_rst", 1, 1'b1, 0, 128, 257, -1);

    // start with the other target during SCAN must be ignored.
    run_sweep("start_in_scan", 0, 1'b1, 0, 1, 257, 20);
    // start in DONE restarts the count from zero.
    run_sweep("restart_from_done", 0, 1'b0, 2, 255, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
